// File: rtl/rega_ctrl.sv
// rega_ctrl: irrigation sequencer driving fill, burst and soak phases
// off an external 5-to-0 countdown counter.
module rega_ctrl #(
  parameter int FILL_MAX    = 16,
  parameter int MAX_RODADAS = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Seco,
  input  logic       NivelBaixo,
  input  logic       Modo,
  input  logic       AckAlarme,
  input  logic [2:0] Cnt,
  output logic       CntRst,
  output logic       ValvEnt,
  output logic       Aspersor,
  output logic       Gotejo,
  output logic       Alarme,
  output logic [2:0] Estado
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    REGA   = 3'd2,
    PAUSA  = 3'd3,
    ALARME = 3'd4
  } state_t;

  localparam logic [7:0] FILL_LAST = 8'(FILL_MAX - 1);
  localparam logic [3:0] RND_MAX   = 4'(MAX_RODADAS);

  state_t     state;
  state_t     state_n;
  logic       modo_q;
  logic       modo_n;
  logic [7:0] fill_q;
  logic [7:0] fill_n;
  logic [3:0] rnd_q;
  logic [3:0] rnd_n;
  logic       cnt_zero;

  assign cnt_zero = (Cnt == 3'd0);
  assign Estado   = state;

  // Reload on the edge a timed phase ends so the next one starts at 5.
  always_comb begin
    CntRst = 1'b1;
    if (state == REGA || state == PAUSA)
      CntRst = cnt_zero;
  end

  always_comb begin
    state_n = state;
    modo_n  = modo_q;
    fill_n  = fill_q;
    rnd_n   = rnd_q;
    case (state)
      IDLE: begin
        if (NivelBaixo) begin
          state_n = FILL;
          fill_n  = '0;
        end else if (Seco && rnd_q == RND_MAX) begin
          state_n = ALARME;
        end else if (Seco) begin
          state_n = REGA;
          modo_n  = Modo;
        end else begin
          rnd_n = '0;
        end
      end
      FILL: begin
        fill_n = fill_q + 8'd1;
        if (!NivelBaixo)
          state_n = IDLE;
        else if (fill_q == FILL_LAST)
          state_n = ALARME;
      end
      REGA: begin
        if (NivelBaixo) begin
          state_n = FILL;
          fill_n  = '0;
        end else if (cnt_zero) begin
          state_n = PAUSA;
        end
      end
      PAUSA: begin
        if (cnt_zero) begin
          state_n = IDLE;
          if (rnd_q != 4'hF)
            rnd_n = rnd_q + 4'd1;
        end
      end
      ALARME: begin
        if (AckAlarme) begin
          state_n = IDLE;
          rnd_n   = '0;
          fill_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they align with Estado.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      modo_q   <= 1'b0;
      fill_q   <= '0;
      rnd_q    <= '0;
      ValvEnt  <= 1'b0;
      Aspersor <= 1'b0;
      Gotejo   <= 1'b0;
      Alarme   <= 1'b0;
    end else begin
      state    <= state_n;
      modo_q   <= modo_n;
      fill_q   <= fill_n;
      rnd_q    <= rnd_n;
      ValvEnt  <= (state_n == FILL);
      Aspersor <= (state_n == REGA) &  modo_n;
      Gotejo   <= (state_n == REGA) & ~modo_n;
      Alarme   <= (state_n == ALARME);
    end
  end

endmodule

// File: tb/tb_rega_ctrl.sv
// tb_rega_ctrl: scenario tasks plus random traffic against a
// phase-duration model of the irrigation sequencer.
module tb_rega_ctrl;

  localparam int FILL_MAX = 16;
  localparam int MAXR     = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Seco = 1'b0;
  logic       NivelBaixo = 1'b0;
  logic       Modo = 1'b0;
  logic       AckAlarme = 1'b0;
  logic [2:0] Cnt = 3'd5;
  logic       CntRst;
  logic       ValvEnt;
  logic       Aspersor;
  logic       Gotejo;
  logic       Alarme;
  logic [2:0] Estado;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase, cycles spent in timed phase, fill cycles, rounds
  int ms = 0;
  int mdw = 0;
  int mfill = 0;
  int mrounds = 0;
  bit mmodo = 1'b0;

  rega_ctrl #(
    .FILL_MAX(FILL_MAX),
    .MAX_RODADAS(MAXR)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Seco(Seco),
    .NivelBaixo(NivelBaixo),
    .Modo(Modo),
    .AckAlarme(AckAlarme),
    .Cnt(Cnt),
    .CntRst(CntRst),
    .ValvEnt(ValvEnt),
    .Aspersor(Aspersor),
    .Gotejo(Gotejo),
    .Alarme(Alarme),
    .Estado(Estado)
  );

  always #5 Clk = ~Clk;

  // 5-to-0 countdown counter attached to the sequencer
  always @(posedge Clk)
    Cnt <= CntRst ? 3'd5 : Cnt - 3'd1;

  task automatic model_update();
    if (Rst) begin
      ms = 0; mdw = 0; mfill = 0; mrounds = 0; mmodo = 0;
      return;
    end
    case (ms)
      0: begin
        if (NivelBaixo) begin
          ms = 1; mfill = 0;
        end else if (Seco && mrounds == MAXR) begin
          ms = 4;
        end else if (Seco) begin
          ms = 2; mdw = 0; mmodo = Modo;
        end else begin
          mrounds = 0;
        end
      end
      1: begin
        mfill++;
        if (!NivelBaixo) ms = 0;
        else if (mfill >= FILL_MAX) ms = 4;
      end
      2: begin
        if (NivelBaixo) begin
          ms = 1; mfill = 0;
        end else begin
          mdw++;
          if (mdw == 6) begin
            ms = 3; mdw = 0;
          end
        end
      end
      3: begin
        mdw++;
        if (mdw == 6) begin
          ms = 0; mdw = 0;
          if (mrounds < 15) mrounds++;
        end
      end
      default: begin
        if (AckAlarme) begin
          ms = 0; mrounds = 0; mfill = 0;
        end
      end
    endcase
  endtask

  function automatic logic [7:0] exp_vec();
    logic cr;
    cr = (ms == 2 || ms == 3) ? (mdw == 5) : 1'b1;
    return {cr, ms == 1, ms == 2 && mmodo,
            ms == 2 && !mmodo, ms == 4, 3'(ms)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {CntRst, ValvEnt, Aspersor, Gotejo, Alarme, Estado};
  endfunction

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    Rst = 1; Seco = 0; NivelBaixo = 0; AckAlarme = 0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (dut_vec() !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", dut_vec(), 8'b1000_0000);
    end
    Rst = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL idle c%0d: got %b want %b",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_drip_round();
    int g;
    int p;
    int first_cnt;
    g = 0; p = 0; first_cnt = -1;
    Seco = 1; Modo = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 8) Seco = 0;
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL drip c%0d: got %b want %b",
                 i, dut_vec(), exp_vec());
      end
      if (Gotejo) begin
        if (first_cnt < 0) first_cnt = int'(Cnt);
        g++;
      end
      if (Estado == 3'd3) p++;
    end
    n_cmp++;
    if (g != 6 || p != 6 || first_cnt != 5) begin
      n_bad++;
      $display("FAIL drip_dwell: got g%0d p%0d c%0d want 6 6 5",
               g, p, first_cnt);
    end
  endtask

  task automatic test_sprinkler_mode();
    int a;
    int g;
    a = 0; g = 0;
    Seco = 1; Modo = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) Modo = 0;
      if (i == 4) Modo = 1;
      if (i == 5) Modo = 0;
      if (i == 7) Seco = 0;
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL sprk c%0d: got %b want %b",
                 i, dut_vec(), exp_vec());
      end
      if (Aspersor) a++;
      if (Gotejo) g++;
    end
    n_cmp++;
    if (a != 6 || g != 0) begin
      n_bad++;
      $display("FAIL sprk_dwell: got a%0d g%0d want 6 0", a, g);
    end
  endtask

  task automatic test_fill_interrupt();
    Seco = 1; Modo = 1'($urandom);
    for (int i = 0; i < 3; i++) step();
    NivelBaixo = 1;
    step();
    n_cmp++;
    if ({Estado, ValvEnt, Aspersor, Gotejo} !== 6'b001_100) begin
      n_bad++;
      $display("FAIL fint_entry: got %b want 001100",
               {Estado, ValvEnt, Aspersor, Gotejo});
    end
    for (int i = 0; i < 4; i++) step();
    NivelBaixo = 0;
    step();
    n_cmp++;
    if (dut_vec() !== exp_vec() || Estado !== 3'd0) begin
      n_bad++;
      $display("FAIL fint_idle: got %b want %b",
               dut_vec(), exp_vec());
    end
    step();
    n_cmp++;
    if (Estado !== 3'd2 || Cnt !== 3'd5) begin
      n_bad++;
      $display("FAIL fint_restart: got e%0d c%0d want 2 5",
               Estado, Cnt);
    end
    Seco = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL fint c%0d: got %b want %b",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fill_timeout();
    int v;
    v = 0;
    Seco = 0; NivelBaixo = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ValvEnt) v++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL fto c%0d: got %b want %b",
                 i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (v != FILL_MAX || Alarme !== 1'b1 || ValvEnt !== 1'b0) begin
      n_bad++;
      $display("FAIL fto_len: got v%0d a%0b want %0d 1",
               v, Alarme, FILL_MAX);
    end
    NivelBaixo = 0; AckAlarme = 1;
    step();
    AckAlarme = 0;
    n_cmp++;
    if (Estado !== 3'd0 || Alarme !== 1'b0) begin
      n_bad++;
      $display("FAIL fto_ack: got e%0d a%0b want 0 0", Estado, Alarme);
    end
  endtask

  task automatic test_dryness();
    int bursts;
    int cyc;
    bit prev;
    bursts = 0; cyc = 0; prev = 0;
    Seco = 1;
    while (!Alarme && cyc < 100) begin
      Modo = 1'($urandom);
      step();
      cyc++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL dry c%0d: got %b want %b",
                 cyc, dut_vec(), exp_vec());
      end
      if (Estado == 3'd2 && !prev) bursts++;
      prev = (Estado == 3'd2);
    end
    n_cmp++;
    if (!Alarme || bursts != MAXR || cyc != 13 * MAXR + 1) begin
      n_bad++;
      $display("FAIL dry_alarm: got b%0d c%0d al%0b want %0d %0d 1",
               bursts, cyc, Alarme, MAXR, 13 * MAXR + 1);
    end
    AckAlarme = 1;
    step();
    AckAlarme = 0;
    for (int i = 0; i < 3; i++) step();
    Rst = 1;
    step();
    Rst = 0;
    Seco = 0;
    n_cmp++;
    if (dut_vec() !== 8'b1000_0000 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL dry_rst: got %b want %b",
               dut_vec(), 8'b1000_0000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      Seco       = ($urandom_range(0, 9) < 7);
      NivelBaixo = ($urandom_range(0, 19) == 0);
      if (ms == 1) NivelBaixo = ($urandom_range(0, 9) < 9);
      Modo       = 1'($urandom);
      AckAlarme  = ($urandom_range(0, 7) == 0);
      Rst        = ($urandom_range(0, 149) == 0);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rand c%0d: got %b want %b",
                 i, dut_vec(), exp_vec());
      end
    end
    Rst = 0;
  endtask

  initial begin
    test_reset();
    test_drip_round();
    test_sprinkler_mode();
    test_fill_interrupt();
    test_fill_timeout();
    test_dryness();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rega_ctrl.md
Name: rega_ctrl

Overview:
- Irrigation sequencer for the automatic-watering datapath; sits directly upstream of the 5-to-0 countdown counter.
- Drives the counter's reset line and consumes its 3-bit count as the irrigation and soak timebase.
- From the soil-dry and tank-low sensors it sequences tank filling, irrigation bursts and soak pauses.
- Drives the inlet valve, sprinkler valve and drip valve, and raises an alarm on fill timeout or persistent dryness.

Parameters:
- FILL_MAX, 16, maximum cycles in FILL with NivelBaixo still high before alarm (2..255).
- MAX_RODADAS, 4, completed irrigate+soak rounds with soil still dry before alarm (1..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Seco  in  1  soil-dry sensor, 1 = dry.
- NivelBaixo  in  1  tank-low sensor, 1 = low.
- Modo  in  1  irrigation mode: 0 = drip (Gotejo), 1 = sprinkler (Aspersor).
- AckAlarme  in  1  operator alarm acknowledge.
- Cnt  in  3  count from the countdown counter {Q2,Q1,Q0}.
- CntRst  out  1  counter reset/load; counter holds 5 while high.
- ValvEnt  out  1  tank inlet valve.
- Aspersor  out  1  sprinkler valve.
- Gotejo  out  1  drip valve.
- Alarme  out  1  alarm lamp.
- Estado  out  3  current state code, for debug.

Behaviour:
- Counter contract: on each Clk edge, CntRst=1 → Cnt=5; otherwise Cnt decrements by 1 (0 wraps). The block never relies on the wrap.
- States and Estado codes: IDLE=0, FILL=1, REGA=2, PAUSA=3, ALARME=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- Reset values: state IDLE; ModoLat=0; fill counter=0; round counter=0; CntRst=1; ValvEnt, Aspersor, Gotejo, Alarme all 0; Estado=0.
- Reset takes effect at any time, including mid-irrigation. All valves close on the following edge.
- CntRst (combinational): 1 in IDLE, FILL and ALARME; in REGA and PAUSA it equals (Cnt==0). This reloads the counter on the same edge the phase ends, so every REGA or PAUSA visit starts with Cnt=5.
- Valve and alarm outputs are Moore, decoded from state (plus ModoLat):
  - ValvEnt=1 only in FILL.
  - Aspersor = (REGA & ModoLat); Gotejo = (REGA & ~ModoLat).
  - Alarme=1 only in ALARME.
- IDLE transitions, in priority order:
  1. NivelBaixo → FILL; fill counter cleared.
  2. Seco & rounds==MAX_RODADAS → ALARME.
  3. Seco → REGA; ModoLat ← Modo.
  4. ~Seco → stay in IDLE; round counter cleared.
- FILL:
  - Fill counter increments each cycle.
  - ~NivelBaixo → IDLE.
  - Else if fill counter reaches FILL_MAX-1 → ALARME, so at most FILL_MAX cycles are spent in FILL.
- REGA:
  - NivelBaixo → FILL (irrigation aborted, round not counted, fill counter cleared). This has priority over Cnt==0.
  - Else Cnt==0 → PAUSA.
  - Nominal dwell is 6 cycles (Cnt 5,4,3,2,1,0).
  - Modo changes during REGA are ignored (ModoLat is held).
- PAUSA:
  - All valves closed; sensors ignored.
  - Cnt==0 → IDLE, round counter +1 (saturating).
  - Dwell is 6 cycles.
- ALARME:
  - Holds until AckAlarme=1, then → IDLE with the round and fill counters cleared.
  - AckAlarme outside ALARME has no effect.
- Simultaneous NivelBaixo and Seco in IDLE: fill first, then irrigation.
- Seco dropping mid-REGA does not shorten the burst.

Test Plan:
- Reset/idle: Rst high 3 cycles, Seco=0 → Estado=0, CntRst=1, all valves and Alarme 0; stays in IDLE for 20 cycles.
- Single round, drip mode: Seco=1, Modo=0, counter model attached. Expected sequence:
  - Gotejo=1 for exactly 6 cycles while Cnt goes 5→0.
  - PAUSA for 6 cycles with valves off.
  - Drop Seco during PAUSA → IDLE, round counter cleared.
- Sprinkler with mode change: Modo=1 at REGA entry, toggle Modo mid-burst → Aspersor stays 1 for the full 6 cycles; Gotejo stays 0.
- Fill interrupt: NivelBaixo=1 at the 3rd REGA cycle → next cycle Estado=1, ValvEnt=1, Aspersor/Gotejo=0. Release NivelBaixo after 5 cycles → IDLE, then REGA restarts with Cnt=5.
- Fill timeout: hold NivelBaixo=1 → ValvEnt high for exactly 16 cycles, then Alarme=1, ValvEnt=0. AckAlarme pulse → IDLE.
- Persistent dryness: hold Seco=1 with MAX_RODADAS=4 → 4 full REGA+PAUSA rounds, then ALARME. Apply Rst mid-REGA in a rerun → all outputs at reset values on the next edge.
